clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period and count registers.
REQ-002 SHALL have parameter N_CH, default 2, number of independent divider channels.
REQ-003 SHALL have parameter DEF_PERIOD, default 4, period loaded by reset.
REQ-004 SHALL have parameter CH_W, default max(1,clog2(N_CH)), channel-select width.
REQ-005 SHALL have port clk  input  1  the only clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  N_CH  per-channel run enable.
REQ-008 SHALL have port period_wr  input  1  one-cycle period write strobe.
REQ-009 SHALL have port period_ch  input  CH_W  channel targeted by the write.
REQ-010 SHALL have port period_in  input  CNT_W  new period, in clk cycles.
REQ-011 SHALL have port period_ack  output  1  one-cycle write acknowledge.
REQ-012 SHALL have port clk_out  output  N_CH  registered divided clock per channel.
REQ-013 SHALL have port tick  output  N_CH  one-cycle pulse at each period start.

Function
REQ-014 Each channel SHALL hold a shadow period, an active period P, and a counter cnt.
REQ-015 With en[i]=1 and P>=2, cnt SHALL count 0..P-1 and wrap to 0.
REQ-016 clk_out[i] SHALL be 1 while cnt < ceil(P/2) and 0 otherwise, e.g. P=4 -> 1100, P=5 -> 11100, P=3 -> 110.
REQ-017 tick[i] SHALL be 1 exactly in cycles where cnt=0, coinciding with the clk_out rising edge.
REQ-018 clk_out and tick SHALL be flop outputs, with no combinational path from any input.
REQ-019 A write with period_wr=1 and period_ch<N_CH SHALL load period_in into that channel's shadow register only.
REQ-020 period_ack SHALL pulse high in the cycle after an accepted write.
REQ-021 A write with period_ch>=N_CH SHALL be ignored and SHALL produce no ack.
REQ-022 When running, the active period SHALL load from the shadow only at wrap (cnt=P-1 -> 0), so no truncated or stretched period is ever emitted.
REQ-023 If a write and a wrap fall in the same cycle, the wrap SHALL load the pre-write shadow, and the new value SHALL apply from the following wrap.
REQ-024 If several writes occur before a wrap, the last write SHALL win.
REQ-025 With en[i]=0, cnt SHALL hold 0, clk_out[i]=0, tick[i]=0, and the active period SHALL track the shadow every cycle.
REQ-026 When en[i] is sampled high after being low, the next cycle SHALL have cnt=0, clk_out=1 and tick=1.
REQ-027 Dropping en[i] mid-period SHALL force clk_out[i]=0 in the next cycle.
REQ-028 An active period of P<2 SHALL halt the channel: cnt=0, clk_out=0, tick=0.
REQ-029 The halted channel SHALL leave the halt only via a shadow load while disabled or at a forced reload, because no wrap occurs while halted.
REQ-030 Because of REQ-029, a write to a halted, enabled channel SHALL load the active period directly, and the channel SHALL start at cnt=0 on the next cycle.
REQ-031 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb another.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, force cnt=0, clk_out=0, tick=0 and period_ack=0.
REQ-033 rst=1 SHALL set the shadow and active periods to DEF_PERIOD on all channels.
REQ-034 Reset assertion mid-period SHALL abort the period with no further output toggles.
REQ-035 On release, channels with en=1 SHALL start per REQ-026 on the first clock edge.

Structure
REQ-036 Package clk_div_pkg SHALL hold the DEF_PERIOD default, the CH_W computation function and the channel state record typedef (shadow, active, cnt).
REQ-037 A sub-module clk_div_chan SHALL implement one channel (counter, shadow/active registers, output decode).
REQ-038 clk_div_multi SHALL instantiate N_CH copies of clk_div_chan via generate and own write decode and ack.

Verification
REQ-039 Reset, en=2'b11, no writes -> both clk_out show 1100 repeating, and tick every 4th cycle aligned to the rising edge.
REQ-040 Write P=3 to ch0 at cnt=1 -> ack on the next cycle, the current 1100 completes, then 110 repeats; ch1 is unchanged.
REQ-041 Write P=5 coinciding with a wrap, then P=6 before the next wrap -> one more 4-cycle period, then 111000 (P=6); 11100 is never seen.
REQ-042 Write P=1 -> channel halts low after the current period; then write P=2 -> 10 pattern starts on the next cycle with tick.
REQ-043 period_ch=2 with N_CH=2 -> no ack, and no channel changes.
REQ-044 rst pulse mid-high phase -> clk_out=0 before the next edge; after release the P=4 default resumes from cnt=0. Dropping en mid-high -> clk_out=0 next cycle.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: defaults, the
// channel-select width helper and the per-channel state record.
package clk_div_pkg;

  localparam int PKG_DEF_PERIOD = 4;

  // Channel state is held at this fixed width; CNT_W must not exceed it.
  localparam int MAX_CNT_W = 32;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] shadow;
    logic [MAX_CNT_W-1:0] active;
    logic [MAX_CNT_W-1:0] cnt;
  } chan_state_t;

  function automatic int calc_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Length of the high phase, ceil(p/2), without overflowing at the top value.
  function automatic logic [MAX_CNT_W-1:0] high_len(input logic [MAX_CNT_W-1:0] p);
    return (p >> 1) + {{(MAX_CNT_W-1){1'b0}}, p[0]};
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active period registers, the period counter and
// the registered clock/tick decode.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = PKG_DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_clk,
  output logic             o_tick
);

  localparam logic [MAX_CNT_W-1:0] DEF_P = MAX_CNT_W'(DEF_PERIOD);
  localparam logic [MAX_CNT_W-1:0] ONE   = MAX_CNT_W'(1);
  localparam logic [MAX_CNT_W-1:0] TWO   = MAX_CNT_W'(2);

  chan_state_t          r_state;
  chan_state_t          w_next;
  logic                 r_en;
  logic                 r_clk;
  logic                 r_tick;
  logic [MAX_CNT_W-1:0] w_wr_val;
  logic                 w_halted;
  logic                 w_wrap;
  logic                 w_run;

  assign w_wr_val = MAX_CNT_W'(i_period);
  assign w_halted = r_state.active < TWO;
  assign w_wrap   = r_state.cnt == (r_state.active - ONE);

  // A halted channel never wraps, so a write to it while enabled reloads the
  // active period directly; otherwise the active period only moves at a wrap.
  always_comb begin
    w_next = r_state;
    if (i_wr) begin
      w_next.shadow = w_wr_val;
    end
    if (!i_en) begin
      w_next.cnt    = '0;
      w_next.active = w_next.shadow;
    end else if (!r_en || w_halted) begin
      w_next.cnt = '0;
      if (w_halted && i_wr) begin
        w_next.active = w_wr_val;
      end
    end else if (w_wrap) begin
      w_next.cnt    = '0;
      w_next.active = r_state.shadow;
    end else begin
      w_next.cnt = r_state.cnt + ONE;
    end
  end

  assign w_run = i_en && (w_next.active >= TWO);

  // Outputs decode the next state so they line up with the registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '{shadow: DEF_P, active: DEF_P, cnt: '0};
      r_en    <= 1'b0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en    <= i_en;
      r_clk   <= w_run && (w_next.cnt < high_len(w_next.active));
      r_tick  <= w_run && (w_next.cnt == '0);
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: period write decode, write
// acknowledge and one clk_div_chan per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int N_CH       = 2,
  parameter int DEF_PERIOD = PKG_DEF_PERIOD,
  parameter int CH_W       = calc_ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             period_wr,
  input  logic [CH_W-1:0]  period_ch,
  input  logic [CNT_W-1:0] period_in,
  output logic             period_ack,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] w_wr_sel;
  logic            w_wr_ok;
  logic            r_ack;

  // Writes to channel numbers beyond N_CH are dropped and never acknowledged.
  assign w_wr_ok = period_wr && (int'(period_ch) < N_CH);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_wr_sel[gi] = w_wr_ok && (int'(period_ch) == gi);

    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_en     (en[gi]),
      .i_wr     (w_wr_sel[gi]),
      .i_period (period_in),
      .o_clk    (clk_out[gi]),
      .o_tick   (tick[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_wr_ok;
    end
  end

  assign period_ack = r_ack;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected {clk_out, tick, period_ack}
// vectors are queued as stimulus is driven and compared after each edge.
module tb_clk_div_multi;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic        period_wr;
  logic [1:0]  period_ch;
  logic [15:0] period_in;
  logic        period_ack;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  int          errors;
  int          checks;
  logic [4:0]  exp_q[$];
  logic [4:0]  obs;
  logic [4:0]  expv;

  // CH_W is widened to 2 so that out-of-range channel numbers can be driven.
  clk_div_multi #(
    .CNT_W      (16),
    .N_CH       (2),
    .DEF_PERIOD (4),
    .CH_W       (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period_wr  (period_wr),
    .period_ch  (period_ch),
    .period_in  (period_in),
    .period_ack (period_ack),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic bit_at(input string s, input int i);
    return s.getc(i) == "1";
  endfunction

  // Packs the per-cycle expected characters in the same order as obs.
  function automatic logic [4:0] exp_vec(input string c0, input string t0,
                                         input string c1, input string t1,
                                         input string ak, input int i);
    return {bit_at(c1, i), bit_at(c0, i), bit_at(t1, i), bit_at(t0, i), bit_at(ak, i)};
  endfunction

  task automatic drive_write(input logic w, input logic [1:0] ch, input logic [15:0] p);
    period_wr = w;
    period_ch = ch;
    period_in = p;
  endtask

  task automatic do_reset(input logic [1:0] en_val);
    rst = 1'b1;
    en  = en_val;
    drive_write(1'b0, 2'd0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    string c0 = "11001100";
    string t0 = "10001000";
    string ak = "00000000";
    rst = 1'b1;
    en  = 2'b11;
    drive_write(1'b1, 2'd0, 16'd3);
    #1;
    exp_q.push_back(5'b0);
    obs  = {clk_out, tick, period_ack};
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL reset_initial: got %b want %b", obs, expv);
    end
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(5'b0);
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL reset_held cycle %0d: got %b want %b", c, obs, expv);
      end
    end
    drive_write(1'b0, 2'd0, 16'd0);
    rst = 1'b0;
    for (int c = 0; c < c0.len(); c++) begin
      exp_q.push_back(exp_vec(c0, t0, c0, t0, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL reset_release cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_default();
    string c0 = "110011001100";
    string t0 = "100010001000";
    string ak = "000000000000";
    do_reset(2'b11);
    for (int c = 0; c < c0.len(); c++) begin
      drive_write(1'b0, 2'd0, 16'd0);
      exp_q.push_back(exp_vec(c0, t0, c0, t0, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL default cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_write_p3();
    string c0 = "1100110110110";
    string t0 = "1000100100100";
    string c1 = "1100110011001";
    string t1 = "1000100010001";
    string ak = "0010000000000";
    do_reset(2'b11);
    for (int c = 0; c < c0.len(); c++) begin
      drive_write(c == 2, 2'd0, 16'd3);
      exp_q.push_back(exp_vec(c0, t0, c1, t1, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL write_p3 cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_last_write_wins();
    string c0 = "11001100111000111000";
    string t0 = "10001000100000100000";
    string c1 = "11001100110011001100";
    string t1 = "10001000100010001000";
    string ak = "00001010000000000000";
    do_reset(2'b11);
    for (int c = 0; c < c0.len(); c++) begin
      drive_write((c == 4) || (c == 6), 2'd0, (c == 6) ? 16'd6 : 16'd5);
      exp_q.push_back(exp_vec(c0, t0, c1, t1, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL last_write_wins cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_halt();
    string c0 = "110000010101";
    string t0 = "100000010101";
    string c1 = "110011001100";
    string t1 = "100010001000";
    string ak = "010000010000";
    do_reset(2'b11);
    for (int c = 0; c < c0.len(); c++) begin
      drive_write((c == 1) || (c == 7), 2'd0, (c == 7) ? 16'd2 : 16'd1);
      exp_q.push_back(exp_vec(c0, t0, c1, t1, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL halt cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_bad_channel();
    string c0 = "110011001100";
    string t0 = "100010001000";
    string ak = "000000000000";
    do_reset(2'b11);
    for (int c = 0; c < c0.len(); c++) begin
      drive_write((c == 2) || (c == 5), (c == 2) ? 2'd2 : 2'd3, 16'd3);
      exp_q.push_back(exp_vec(c0, t0, c0, t0, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL bad_channel cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_and_enable();
    string p0 = "11001";
    string q0 = "10001";
    string z0 = "00000";
    string c0 = "1100110010011";
    string t0 = "1000100010010";
    string c1 = "1100110011001";
    string t1 = "1000100010001";
    string ak = "0000000000000";
    do_reset(2'b11);
    for (int c = 0; c < p0.len(); c++) begin
      exp_q.push_back(exp_vec(p0, q0, p0, q0, z0, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL pre_reset cycle %0d: got %b want %b", c, obs, expv);
      end
    end
    #3;
    rst = 1'b1;
    #1;
    exp_q.push_back(5'b0);
    obs  = {clk_out, tick, period_ack};
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b want %b", obs, expv);
    end
    exp_q.push_back(5'b0);
    @(posedge clk);
    #1;
    obs  = {clk_out, tick, period_ack};
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL reset_hold_edge: got %b want %b", obs, expv);
    end
    rst = 1'b0;
    for (int c = 0; c < c0.len(); c++) begin
      en = ((c == 9) || (c == 10)) ? 2'b10 : 2'b11;
      exp_q.push_back(exp_vec(c0, t0, c1, t1, ak, c));
      @(posedge clk);
      #1;
      obs  = {clk_out, tick, period_ack};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL resume_en_drop cycle %0d: got %b want %b", c, obs, expv);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_default();
    test_write_p3();
    test_last_write_wins();
    test_halt();
    test_bad_channel();
    test_reset_mid_and_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
